fp_mult_pipe: RTL

- Parametrised, 3-stage pipelined IEEE-754-style floating-point multiplier for the datapath FP units. Default configuration is binary32.
- Successor to the combinational multiplier. Adds round-to-nearest-even, special-value handling, registered overflow/underflow/exception flags, and a valid/ready stream interface with backpressure.

---
 rtl/fp_mult_pipe.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: three-stage pipelined floating-point multiplier.
// The default parameters give binary32. Subnormal inputs are read as zero and
// subnormal results are flushed to zero. Rounding is round-to-nearest-even.
// The result flags are registered and sit next to the result.
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = 1 + EXP_W + MAN_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            exception
);

  localparam int PW   = 2 * MAN_W + 2;        // full significand product width
  localparam int EW2  = EXP_W + 2;            // signed working exponent width
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;
  localparam logic [EW2-1:0]  EMAX_E = EW2'(EMAX);
  localparam logic [XLEN-1:0] QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand class. It is resolved in stage 1 and carried down the pipe.
  typedef enum logic [1:0] {K_NUM, K_ZERO, K_INF, K_NAN} kind_e;

  // Handshake: a pair is taken on a clock edge where in_valid && in_ready.
  // A result leaves on an edge where out_valid && out_ready.
  // stall = out_valid && !out_ready freezes all three stages, and bubbles
  // included. in_ready is the combinational inverse of stall.
  logic stall;

  logic                v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic                s1_d, s1_q, s2_d, s2_q;
  kind_e               k1_d, k1_q, k2_d, k2_q;
  logic [PW-1:0]       prod1_d, prod1_q;
  logic [EW2-1:0]      exp1_d, exp1_q, exp2_d, exp2_q;
  logic [MAN_W-1:0]    frac2_d, frac2_q;
  logic [XLEN-1:0]     result_d, result_q;
  logic                ovf_d, ovf_q, udf_d, udf_q, exc_d, exc_q;

  // Unpacked operand fields.
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea     = a[MAN_W +: EXP_W];
  assign eb     = b[MAN_W +: EXP_W];
  assign fa     = a[MAN_W-1:0];
  assign fb     = b[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (ea == '1) && (fa == '0);
  assign b_inf  = (eb == '1) && (fb == '0);
  assign a_nan  = (ea == '1) && (fa != '0);
  assign b_nan  = (eb == '1) && (fb != '0);

  assign stall     = v3_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = v3_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;
  assign exception = exc_q;

  // Stage 1: classify the operands, multiply the significands, and add the exponents.
  always_comb begin
    v1_d    = in_valid;
    s1_d    = a[XLEN-1] ^ b[XLEN-1];
    prod1_d = PW'({1'b1, fa}) * PW'({1'b1, fb});
    exp1_d  = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) k1_d = K_NAN;
    else if (a_inf || b_inf)                                      k1_d = K_INF;
    else if (a_zero || b_zero)                                    k1_d = K_ZERO;
    else                                                          k1_d = K_NUM;
  end

  // Stage 2: normalise so the leading one is the top bit, then apply round-to-nearest-even.
  logic             norm, guard_b, sticky_b, round_up, rcarry;
  logic [PW-2:0]    prod_n;
  logic [MAN_W-1:0] frac_t;
  logic [MAN_W:0]   frac_r;

  always_comb begin
    norm     = prod1_q[PW-1];
    // The leading one has been dropped. Bit PW-2 is the first fraction bit.
    prod_n   = norm ? prod1_q[PW-2:0] : {prod1_q[PW-3:0], 1'b0};
    frac_t   = prod_n[PW-2 -: MAN_W];
    guard_b  = prod_n[MAN_W];
    sticky_b = |prod_n[MAN_W-1:0];
    round_up = guard_b & (sticky_b | frac_t[0]);
    frac_r   = {1'b0, frac_t} + (MAN_W+1)'(round_up);
    // If the increment carries out, the fraction becomes all zeros and the exponent goes up by one.
    rcarry   = frac_r[MAN_W];
    v2_d     = v1_q;
    s2_d     = s1_q;
    k2_d     = k1_q;
    frac2_d  = frac_r[MAN_W-1:0];
    exp2_d   = exp1_q + EW2'(norm) + EW2'(rcarry);
  end

  // Stage 3: check the exponent range and pack the word. The word and the flags stay zero for a bubble.
  always_comb begin
    v3_d     = v2_q;
    result_d = '0;
    ovf_d    = 1'b0;
    udf_d    = 1'b0;
    exc_d    = 1'b0;
    if (v2_q) begin
      unique case (k2_q)
        K_NAN: begin
          result_d = QNAN;
          exc_d    = 1'b1;
        end
        K_INF:  result_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        K_ZERO: result_d = {s2_q, {(EXP_W+MAN_W){1'b0}}};
        default: begin
          if ($signed(exp2_q) >= $signed(EMAX_E)) begin
            result_d = {s2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
          end else if (exp2_q[EW2-1] || (exp2_q == '0)) begin
            result_d = {s2_q, {(EXP_W+MAN_W){1'b0}}};
            udf_d    = 1'b1;
          end else begin
            result_d = {s2_q, exp2_q[EXP_W-1:0], frac2_q};
          end
        end
      endcase
    end
  end

  // Pipeline registers. They all advance together unless the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      v3_q     <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      k1_q     <= K_NUM;
      k2_q     <= K_NUM;
      prod1_q  <= '0;
      exp1_q   <= '0;
      exp2_q   <= '0;
      frac2_q  <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      exc_q    <= 1'b0;
    end else if (!stall) begin
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      v3_q     <= v3_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      k1_q     <= k1_d;
      k2_q     <= k2_d;
      prod1_q  <= prod1_d;
      exp1_q   <= exp1_d;
      exp2_q   <= exp2_d;
      frac2_q  <= frac2_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      exc_q    <= exc_d;
    end
  end

endmodule
